cla_pipe_addsub: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Operand width is a multiple of the 4-bit lookahead group. Supports add, subtract, add-with-carry and subtract-with-borrow, and reports carry-out, signed overflow and zero. It is the clocked, width-generic successor to the fixed 16-bit combinational lookahead adder, intended to sit between register-file operand fetch and writeback in the datapath.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_group4.sv | 26 ++
 rtl/cla_pipe_addsub.sv | 167 ++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and group propagate/generate helper for cla_pipe_addsub
package cla_pkg;

    localparam int GROUP = 4;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBB = 2'b11
    } op_t;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    function automatic grp_pg_t group_pg(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
        grp_pg_t r;
        r.p = &p;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit in-group lookahead: sum bits and carries from the group carry-in
module cla_group4
    import cla_pkg::*;
(
    input  logic             i_cin,
    input  logic [GROUP-1:0] i_p,
    input  logic [GROUP-1:0] i_g,
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_bb,
    output logic [GROUP-1:0] o_sum,
    output logic [GROUP-1:0] o_carry
);

    logic [GROUP-1:0] w_c;

    // every carry is expanded from i_cin directly, so no bit waits on its neighbour
    assign w_c[0] = i_cin;
    assign w_c[1] = i_g[0] | (i_p[0] & i_cin);
    assign w_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    assign w_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_cin);

    assign o_sum   = i_a ^ i_bb ^ w_c;
    assign o_carry = w_c;

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - two-stage pipelined carry-lookahead add/sub with valid/ready on both sides
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4 within 4..64");
    end

    function automatic logic group_carry(input logic [NG-1:0] gp, input logic [NG-1:0] gg,
                                         input logic c0, input int k);
        logic v_prod;
        logic v_acc;
        v_prod = 1'b1;
        v_acc  = 1'b0;
        for (int j = k - 1; j >= 0; j--) begin
            v_acc  = v_acc | (v_prod & gg[j]);
            v_prod = v_prod & gp[j];
        end
        return v_acc | (v_prod & c0);
    endfunction

    logic             w_s1_en;
    logic             w_s2_en;
    logic [WIDTH-1:0] w_bb;
    logic             w_c0;
    logic [NG-1:0]    w_in_gp;
    logic [NG-1:0]    w_in_gg;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_bb;
    logic             r_s1_c0;
    logic [NG-1:0]    r_s1_gp;
    logic [NG-1:0]    r_s1_gg;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_s2_en  = !r_out_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    always_comb begin
        w_bb = b;
        w_c0 = 1'b0;
        case (op)
            ADD: w_c0 = 1'b0;
            SUB: begin
                w_bb = ~b;
                w_c0 = 1'b1;
            end
            ADC: w_c0 = cin;
            SBB: begin
                w_bb = ~b;
                w_c0 = cin;
            end
            default: w_c0 = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_in_pg
        grp_pg_t w_pg;
        assign w_pg = group_pg(a[gi*GROUP +: GROUP] | w_bb[gi*GROUP +: GROUP],
                               a[gi*GROUP +: GROUP] & w_bb[gi*GROUP +: GROUP]);
        assign w_in_gp[gi] = w_pg.p;
        assign w_in_gg[gi] = w_pg.g;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_bb    <= '0;
            r_s1_c0    <= 1'b0;
            r_s1_gp    <= '0;
            r_s1_gg    <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= a;
                r_s1_bb <= w_bb;
                r_s1_c0 <= w_c0;
                r_s1_gp <= w_in_gp;
                r_s1_gg <= w_in_gg;
            end
        end
    end

    assign w_p     = r_s1_a | r_s1_bb;
    assign w_g     = r_s1_a & r_s1_bb;
    assign w_gc[0] = r_s1_c0;

    // each group carry is a flat sum of products over the registered P/G, not a chain
    for (genvar k = 1; k <= NG; k++) begin : g_gc
        assign w_gc[k] = group_carry(r_s1_gp, r_s1_gg, r_s1_c0, k);
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group4 u_grp (
            .i_cin   (w_gc[gi]),
            .i_p     (w_p[gi*GROUP +: GROUP]),
            .i_g     (w_g[gi*GROUP +: GROUP]),
            .i_a     (r_s1_a[gi*GROUP +: GROUP]),
            .i_bb    (r_s1_bb[gi*GROUP +: GROUP]),
            .o_sum   (w_sum[gi*GROUP +: GROUP]),
            .o_carry (w_carry[gi*GROUP +: GROUP])
        );
    end

    // operands of equal sign overflow exactly when carry into and out of the MSB differ
    assign w_ovf = w_carry[WIDTH-1] ^ w_gc[NG];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_gc[NG];
                r_ovf  <= w_ovf;
                r_zero <= ~|w_sum;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - scoreboard bench running WIDTH 4/16/32/64 instances in lockstep
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    op_t         op;
    logic [63:0] a64;
    logic [63:0] b64;

    logic rdy4, rdy16, rdy32, rdy64;
    logic ov4, ov16, ov32, ov64;
    logic co4, co16, co32, co64;
    logic of4, of16, of32, of64;
    logic z4, z16, z32, z64;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic [63:0] sum64;

    cla_pipe_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(rdy4), .a(a64[3:0]), .b(b64[3:0]),
        .cin(cin), .op(op), .out_valid(ov4), .out_ready(out_ready), .sum(sum4), .cout(co4),
        .ovf(of4), .zero(z4));
    cla_pipe_addsub #(.WIDTH(16)) u16 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(rdy16), .a(a64[15:0]), .b(b64[15:0]),
        .cin(cin), .op(op), .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(co16),
        .ovf(of16), .zero(z16));
    cla_pipe_addsub #(.WIDTH(32)) u32 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(rdy32), .a(a64[31:0]), .b(b64[31:0]),
        .cin(cin), .op(op), .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .cout(co32),
        .ovf(of32), .zero(z32));
    cla_pipe_addsub #(.WIDTH(64)) u64 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(rdy64), .a(a64), .b(b64),
        .cin(cin), .op(op), .out_valid(ov64), .out_ready(out_ready), .sum(sum64), .cout(co64),
        .ovf(of64), .zero(z64));

    logic [127:0] snap;
    assign snap = {sum64, sum32, sum16, sum4, co64, of64, z64, co32, of32, z32,
                   co16, of16, z16, co4, of4, z4};

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        op_t         op;
        logic        c;
        int          stamp;
        logic        hk;
        int          kidx;
        logic [66:0] kv;
    } beat_t;

    beat_t        q[$];
    int           ws[4] = '{4, 16, 32, 64};
    int           checks = 0;
    int           errors = 0;
    int           edges = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_snap = '0;
    logic         accepted = 1'b0;

    logic        d_iv = 1'b0;
    logic        d_or = 1'b1;
    logic [63:0] d_a = '0;
    logic [63:0] d_b = '0;
    op_t         d_op = ADD;
    logic        d_c = 1'b0;
    logic        d_hk = 1'b0;
    int          d_kidx = 0;
    logic [66:0] d_kv = '0;

    logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {cout, ovf, zero, sum} from a plain (w+1)-bit behavioural sum
    function automatic logic [66:0] model(input logic [63:0] ra, input logic [63:0] rb,
                                          input op_t rop, input logic rc, input int w);
        logic [64:0] mask, aa, bv, full;
        logic [63:0] s;
        logic        c0, co, of, zz;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, ra} & mask;
        bv   = ((rop == SUB || rop == SBB) ? {1'b0, ~rb} : {1'b0, rb}) & mask;
        c0   = (rop == ADD) ? 1'b0 : (rop == SUB) ? 1'b1 : rc;
        full = aa + bv + {64'd0, c0};
        co   = full[w];
        s    = full[63:0] & mask[63:0];
        of   = (aa[w-1] == bv[w-1]) && (s[w-1] != aa[w-1]);
        zz   = (s == 64'd0);
        return {co, of, zz, s};
    endfunction

    function automatic logic [66:0] observed(input int idx);
        case (idx)
            0:       return {co4, of4, z4, 60'd0, sum4};
            1:       return {co16, of16, z16, 48'd0, sum16};
            2:       return {co32, of32, z32, 32'd0, sum32};
            default: return {co64, of64, z64, sum64};
        endcase
    endfunction

    task automatic cycle();
        beat_t e;
        logic  ov_exp;
        @(negedge clk);
        in_valid  = d_iv;
        out_ready = d_or;
        a64       = d_a;
        b64       = d_b;
        op        = d_op;
        cin       = d_c;
        #1;
        accepted = 1'b0;
        chk("in_ready", {124'd0, rdy4, rdy16, rdy32, rdy64},
            {124'd0, {4{!((q.size() == 2) && !out_ready)}}});
        ov_exp = (q.size() > 0) && (edges >= q[0].stamp + 2);
        chk("out_valid", {124'd0, ov4, ov16, ov32, ov64}, {124'd0, {4{ov_exp}}});
        if (prev_stall) chk("hold_stable", snap, prev_snap);
        if (ov16 && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 128'd1, 128'd0);
            end else begin
                e = q.pop_front();
                for (int i = 0; i < 4; i++)
                    chk($sformatf("result_w%0d", ws[i]), {61'd0, observed(i)},
                        {61'd0, model(e.a, e.b, e.op, e.c, ws[i])});
                if (e.hk) chk("directed_value", {61'd0, observed(e.kidx)}, {61'd0, e.kv});
            end
        end
        if (in_valid && rdy16) begin
            e.a = a64; e.b = b64; e.op = op; e.c = cin; e.stamp = edges;
            e.hk = d_hk; e.kidx = d_kidx; e.kv = d_kv;
            q.push_back(e);
            accepted = 1'b1;
        end
        prev_stall = ov16 && !out_ready;
        prev_snap  = snap;
    endtask

    task automatic directed(input op_t o, input logic [63:0] x, input logic [63:0] y,
                            input logic c, input int kidx, input logic [66:0] kv);
        int n;
        n = 0;
        d_iv = 1'b1; d_or = 1'b1; d_a = x; d_b = y; d_op = o; d_c = c;
        d_hk = 1'b1; d_kidx = kidx; d_kv = kv;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 10);
        chk("directed_accept", {127'd0, accepted}, 128'd1);
        d_iv = 1'b0;
        d_hk = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        d_iv = 1'b0;
        d_or = 1'b1;
        while (q.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        chk(tag, {96'd0, 32'(q.size())}, 128'd0);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return 64'h8000_0000_0000_8000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int sent;
        int n;
        int acc_cnt;

        nrst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cin = 1'b1; op = SUB;
        a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'h0FED_CBA9_8765_4321;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", {124'd0, ov4, ov16, ov32, ov64}, 128'd0);
        chk("reset_outputs", snap, 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        nrst = 1'b1;
        #1;
        chk("ready_after_reset", {124'd0, rdy4, rdy16, rdy32, rdy64}, 128'hF);

        directed(ADD, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1, {1'b1, 1'b0, 1'b1, 64'h0});
        directed(ADD, 64'h0000_0000_0000_7FFF, 64'h1, 1'b0, 1, {1'b0, 1'b1, 1'b0, 64'h8000});
        directed(SUB, 64'h5, 64'h7, 1'b0, 1, {1'b0, 1'b0, 1'b0, 64'hFFFE});
        directed(SUB, 64'h8000, 64'h1, 1'b1, 1, {1'b1, 1'b1, 1'b0, 64'h7FFF});
        directed(ADC, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 2, {1'b1, 1'b0, 1'b1, 64'h0});
        directed(SBB, 64'h0, 64'h0, 1'b0, 2, {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF});
        drain("directed_drain");

        sent = 0;
        n = 0;
        while ((sent < 8 || q.size() > 0) && n < 200) begin
            d_iv = (sent < 8);
            d_a  = rand_operand();
            d_b  = rand_operand();
            d_op = op_t'($urandom_range(0, 3));
            d_c  = 1'($urandom_range(0, 1));
            d_or = pat[n % 8];
            cycle();
            if (accepted) sent++;
            n++;
        end
        chk("backpressure_beats", {96'd0, 32'(sent), 32'(q.size())}, {96'd0, 32'd8, 32'd0});

        acc_cnt = 0;
        d_iv = 1'b1;
        d_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d_a  = rand_operand();
            d_b  = rand_operand();
            d_op = op_t'($urandom_range(0, 3));
            d_c  = 1'($urandom_range(0, 1));
            cycle();
            if (accepted) acc_cnt++;
        end
        chk("throughput", {96'd0, 32'(acc_cnt)}, {96'd0, 32'd40});

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                @(negedge clk);
                nrst = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("async_reset_valid", {124'd0, ov4, ov16, ov32, ov64}, 128'd0);
                chk("async_reset_outputs", snap, 128'd0);
                chk("async_reset_ready", {124'd0, rdy4, rdy16, rdy32, rdy64}, 128'hF);
                q.delete();
                prev_stall = 1'b0;
                @(negedge clk);
                nrst = 1'b1;
            end
            d_iv = ($urandom_range(0, 3) != 0);
            d_or = ($urandom_range(0, 3) != 0);
            d_a  = rand_operand();
            d_b  = rand_operand();
            d_op = op_t'($urandom_range(0, 3));
            d_c  = 1'($urandom_range(0, 1));
            cycle();
        end
        drain("soak_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
